// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_controller
//  Description : Instruction register, 16-bit instruction decode and Moore
//                FSM that sequences the datapath strobes for MOV imm,
//                MOV reg and the ADD/CMP/AND/MVN ALU instructions.
//                Start/wait handshake: s launches, w flags idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller #(
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic          load,
    input  logic [IW-1:0] in,
    output logic          w,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic [3:0]    vsel,
    output logic          loada,
    output logic          loadb,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic          loadc,
    output logic          loads,
    output logic [IW-1:0] sximm8,
    output logic [IW-1:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    // One-hot writeback mux selects
    localparam logic [3:0] c_VSEL_IMM8 = 4'b0100;
    localparam logic [3:0] c_VSEL_C    = 4'b0001;

    state_t        r_state;
    state_t        w_next_state;
    logic [IW-1:0] r_ir;

    // Instruction fields
    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;

    // Instruction classes
    logic w_is_mov_imm;
    logic w_is_mov_reg;
    logic w_is_alu;
    logic w_is_mvn;
    logic w_is_cmp;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign w_is_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_alu     = (w_opcode == 3'b101);
    assign w_is_mvn     = w_is_alu && (w_op == 2'b11);
    assign w_is_cmp     = w_is_alu && (w_op == 2'b01);

    // Immediates follow the IR in every state
    assign sximm8 = {{(IW-8){r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{(IW-5){r_ir[4]}}, r_ir[4:0]};

    // State register; reset drops straight back to idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction register only accepts a new word while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir <= '0;
        end else if ((r_state == S_WAIT) && load) begin
            r_ir <= in;
        end
    end

    // Next-state logic and Moore strobe decode
    always_comb begin
        w_next_state = r_state;
        w            = 1'b0;
        readnum      = 3'd0;
        writenum     = 3'd0;
        write        = 1'b0;
        vsel         = 4'b0000;
        loada        = 1'b0;
        loadb        = 1'b0;
        asel         = 1'b0;
        bsel         = 1'b0;
        shift        = 2'b00;
        ALUop        = 2'b00;
        loadc        = 1'b0;
        loads        = 1'b0;

        case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                if (w_is_mov_imm) begin
                    w_next_state = S_WRITE_IMM;
                end else if (w_is_mov_reg || w_is_mvn) begin
                    w_next_state = S_GET_B;
                end else if (w_is_alu) begin
                    w_next_state = S_GET_A;
                end else begin
                    // Illegal encoding: abandon without touching state
                    w_next_state = S_WAIT;
                end
            end

            S_WRITE_IMM: begin
                writenum     = w_rn;
                vsel         = c_VSEL_IMM8;
                write        = 1'b1;
                w_next_state = S_WAIT;
            end

            S_GET_A: begin
                readnum      = w_rn;
                loada        = 1'b1;
                w_next_state = S_GET_B;
            end

            S_GET_B: begin
                readnum      = w_rm;
                loadb        = 1'b1;
                w_next_state = S_EXEC;
            end

            S_EXEC: begin
                shift = w_sh;
                // MOV reg is realised as 0 + shifted B
                ALUop = w_is_alu ? w_op : 2'b00;
                asel  = w_is_mov_reg;
                loadc = !w_is_cmp;
                loads = w_is_cmp;
                w_next_state = w_is_cmp ? S_WAIT : S_WRITE_REG;
            end

            S_WRITE_REG: begin
                writenum     = w_rd;
                vsel         = c_VSEL_C;
                write        = 1'b1;
                w_next_state = S_WAIT;
            end

            default: begin
                w_next_state = S_WAIT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Control stage directly upstream of the datapath. It holds the instruction register, decodes the 16-bit instruction, and runs a Moore FSM. The FSM sequences the datapath strobes (readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel, shift, ALUop) and supplies sximm8 and sximm5. Handshake with the outside is start/wait: s launches one instruction, and w marks the idle state.

Parameters:
IW, 16, instruction width (fixed ISA encoding below; not meant to be overridden)

Ports:
clk      input   1   rising-edge clock
reset    input   1   asynchronous, active-high reset
s        input   1   start; sampled only in WAIT
load     input   1   load instruction register from in; honoured only in WAIT
in       input   16  instruction word
w        output  1   1 when FSM is in WAIT
readnum  output  3   register-file read index
writenum output  3   register-file write index
write    output  1   register-file write enable
vsel     output  4   one-hot writeback select: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C
loada    output  1   load A register
loadb    output  1   load B register
asel     output  1   1 forces ALU A input to 0
bsel     output  1   1 selects sximm5 as ALU B input
shift    output  2   shifter control: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
ALUop    output  2   00 ADD, 01 SUB/CMP, 10 AND, 11 NOT B
loadc    output  1   load C register
loads    output  1   load Z/N/V status
sximm8   output  16  sign-extended IR[7:0]
sximm5   output  16  sign-extended IR[4:0]

Behaviour:
- Clock, reset and IR: one clock, clk. reset is asynchronous and active-high. On reset: state=WAIT, IR=16'h0000, w=1, all strobes 0, indices 0, vsel=0000, shift=00, ALUop=00.
- Decode fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Instruction set:
  - MOV Rn,#imm8: opcode 110, op 10.
  - MOV Rd,Rm{,sh}: opcode 110, op 00.
  - ALU Rd,Rn,Rm{,sh}: opcode 101. op 00 ADD, op 01 CMP (no writeback), op 10 AND, op 11 MVN (Rn unused).
  - All other opcode/op combinations are illegal.
- IR loads from in on a rising clk edge when load=1 and state=WAIT. load is ignored in every other state, so IR is stable for the whole instruction.
- sximm8 and sximm5 are combinational from IR in every state.
- All other outputs are Moore outputs decoded from state (plus IR fields). Any strobe not listed for a state is 0.
- States and strobes:
  - WAIT: w=1. s=1 -> DECODE. If load and s are both 1 on the same edge, IR captures the new word and DECODE uses it.
  - DECODE: no strobes. Next state: MOV imm -> WRITE_IMM; MOV reg -> GET_B; MVN -> GET_B; ADD/CMP/AND -> GET_A; illegal -> WAIT (no register write, no status change).
  - WRITE_IMM: writenum=Rn, vsel=0100, write=1. Next: WAIT.
  - GET_A: readnum=Rn, loada=1. Next: GET_B.
  - GET_B: readnum=Rm, loadb=1. Next: EXEC.
  - EXEC: shift=sh, bsel=0, ALUop=op for ALU instructions and ALUop=00 for MOV reg. asel=1 for MOV reg, else 0. loadc=1 except for CMP. loads=1 only for CMP. Next: WAIT for CMP, else WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=0001, write=1. Next: WAIT.
- Latency, counted as edges from the s-sampling edge to w=1: MOV imm 3; MOV reg 5; MVN 5; CMP 5; ADD/AND 6; illegal 2.
- s is ignored outside WAIT. s held high re-launches the current IR on every return to WAIT.
- Reset asserted mid-instruction drops to WAIT immediately and asynchronously. No further write strobe is issued.
- write is never asserted in the same cycle as loada or loadb.

Test Plan:
- Reset, then load in=16'hD1FC and pulse s -> DECODE, then WRITE_IMM with writenum=1, vsel=0100, write=1, sximm8=16'hFFFC; w=1 on the 3rd edge.
- in=16'hA148 (ADD R2,R1,R0,LSL#1) -> GET_A with readnum=1, loada=1; GET_B with readnum=0, loadb=1; EXEC with shift=01, ALUop=00, loadc=1, loads=0; WRITE_REG with writenum=2, vsel=0001, write=1; w=1 after 6 edges.
- in=16'hA900 (CMP R1,R0) -> EXEC with ALUop=01, loads=1, loadc=0; no WRITE_REG and write never 1; w=1 after 5 edges.
- in=16'hC099 (MOV R4,R1,ASR) -> skips GET_A; GET_B with readnum=1; EXEC with asel=1, shift=11, ALUop=00; WRITE_REG with writenum=4.
- in=16'hB860 (MVN R3,R0) -> skips GET_A; EXEC with ALUop=11. in=16'h0000 (illegal) -> DECODE then WAIT, write=0 throughout.
- Assert reset during GET_B of 16'hA148 -> w=1 and all strobes 0 before the next clk edge. load=1 with in=16'hD007 while busy -> IR unchanged.
